nibble_pack_ctrl: RTL and testbench



---
 rtl/nibble_pack_ctrl.sv | 108 ++++++++++
 tb/tb_nibble_pack_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_pack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_pack_ctrl
//  Purpose  : Packs a valid/ready stream of NIB_W-bit nibbles into
//             NIB_W*NUM_NIBS-bit words through a slice-written holding
//             register. Supports an early flush that closes a partial word
//             with zero padding in the unused slots.
//  Options  : NIBBLE_PACK_LSB_FIRST_EN - when defined, nibble k lands in the
//             k-th field from the LSB. By default nibble 0 is the MSB field.
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_pack_ctrl #(
  parameter int NIB_W    = 4,
  parameter int NUM_NIBS = 2,
  parameter int CNT_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [NIB_W-1:0]          in_data,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [NIB_W*NUM_NIBS-1:0] out_data,
  output logic                      out_pad,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          slot
);

  localparam int OUT_W = NIB_W * NUM_NIBS;

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_FILLING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_slot;
  logic [OUT_W-1:0] r_hold;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_pad;

  logic             w_in_ready;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_fill_done;
  logic             w_slot_nz;
  logic             w_flush_take;
  logic             w_close;
  logic [OUT_W-1:0] w_hold_wr;

  // Handshake qualifiers; a full word may be replaced in the same cycle it is consumed
  always_comb begin
    w_in_ready   = (r_state != S_FULL) || out_ready;
    w_in_acc     = in_valid && w_in_ready;
    w_out_acc    = (r_state == S_FULL) && out_ready;
    w_fill_done  = w_in_acc && (r_slot == CNT_W'(NUM_NIBS - 1));
    // Slot count after a same-cycle accept is what makes a flush meaningful
    w_slot_nz    = (r_slot != '0) || w_in_acc;
    w_flush_take = flush && w_in_ready && w_slot_nz;
    w_close      = w_fill_done || w_flush_take;
  end

  // Holding register with the accepted nibble written into its slot
  always_comb begin
    w_hold_wr = r_hold;
    for (int k = 0; k < NUM_NIBS; k++) begin
      if (w_in_acc && (r_slot == CNT_W'(k))) begin
`ifdef NIBBLE_PACK_LSB_FIRST_EN
        w_hold_wr[k*NIB_W +: NIB_W] = in_data;
`else
        w_hold_wr[(NUM_NIBS-1-k)*NIB_W +: NIB_W] = in_data;
`endif
      end
    end
  end

  // Sequencer: fill slots, close words on last slot or flush, release on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_slot     <= '0;
      r_hold     <= '0;
      r_out_data <= '0;
      r_out_pad  <= 1'b0;
    end else if (w_close) begin
      // Holding register is cleared so no stale nibble reaches a padded word
      r_out_data <= w_hold_wr;
      r_out_pad  <= !w_fill_done;
      r_slot     <= '0;
      r_hold     <= '0;
      r_state    <= S_FULL;
    end else if (w_in_acc) begin
      r_hold     <= w_hold_wr;
      r_slot     <= r_slot + CNT_W'(1);
      r_state    <= S_FILLING;
    end else if (w_out_acc) begin
      r_state    <= S_EMPTY;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_out_data;
  assign out_pad   = r_out_pad;
  assign slot      = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_nibble_pack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_pack_ctrl
//  Purpose  : Directed self-checking bench for nibble_pack_ctrl (defaults).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_pack_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_pad;
  logic       out_ready;
  logic [0:0] slot;

  int n_checks;
  int n_errors;

  nibble_pack_ctrl #(.NIB_W(4), .NUM_NIBS(2), .CNT_W(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_pad   (out_pad),
    .out_ready (out_ready),
    .slot      (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word for first nibble a, second nibble b
  function automatic logic [7:0] exw(input logic [3:0] a, input logic [3:0] b);
`ifdef NIBBLE_PACK_LSB_FIRST_EN
    return {b, a};
`else
    return {a, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs and let combinational outputs settle
  task automatic drive(input logic v, input logic [3:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [3:0] d, input logic f, input logic r);
    drive(v, d, f, r);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_ov",   32'(out_valid), 32'd0);
    chk("rst_slot", 32'(slot),      32'd0);
    chk("rst_data", 32'(out_data),  32'd0);
    chk("rst_pad",  32'(out_pad),   32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Basic pair A,5
    cyc(1'b1, 4'hA, 1'b0, 1'b1);
    chk("a5_slot1", 32'(slot), 32'd1);
    chk("a5_ov0",   32'(out_valid), 32'd0);
    cyc(1'b1, 4'h5, 1'b0, 1'b1);
    chk("a5_ov",    32'(out_valid), 32'd1);
    chk("a5_data",  32'(out_data),  32'(exw(4'hA, 4'h5)));
    chk("a5_pad",   32'(out_pad),   32'd0);
    chk("a5_slot0", 32'(slot),      32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("a5_ovoff", 32'(out_valid), 32'd0);

    // Back-to-back 1,2,3,4
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    step();
    chk("b2b_ov1", 32'(out_valid), 32'd0);
    drive(1'b1, 4'h2, 1'b0, 1'b1);
    chk("b2b_rdy2", 32'(in_ready), 32'd1);
    step();
    chk("b2b_w12", 32'(out_data), 32'(exw(4'h1, 4'h2)));
    chk("b2b_ov2", 32'(out_valid), 32'd1);
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    chk("b2b_rdy3", 32'(in_ready), 32'd1);
    step();
    chk("b2b_ov3",   32'(out_valid), 32'd0);
    chk("b2b_slot3", 32'(slot),      32'd1);
    drive(1'b1, 4'h4, 1'b0, 1'b1);
    chk("b2b_rdy4", 32'(in_ready), 32'd1);
    step();
    chk("b2b_w34", 32'(out_data),  32'(exw(4'h3, 4'h4)));
    chk("b2b_ov4", 32'(out_valid), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("b2b_end", 32'(out_valid), 32'd0);

    // Stall: C,D with out_ready low, F must be ignored
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'hD, 1'b0, 1'b0);
    chk("st_ov",   32'(out_valid), 32'd1);
    chk("st_data", 32'(out_data),  32'(exw(4'hC, 4'hD)));
    drive(1'b1, 4'hF, 1'b0, 1'b0);
    chk("st_rdy0", 32'(in_ready), 32'd0);
    step();
    chk("st_hold",  32'(out_data), 32'(exw(4'hC, 4'hD)));
    chk("st_slot0", 32'(slot),     32'd0);
    // Flush while stalled is ignored
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("st_fl_data", 32'(out_data), 32'(exw(4'hC, 4'hD)));
    chk("st_fl_pad",  32'(out_pad),  32'd0);
    drive(1'b1, 4'hE, 1'b0, 1'b1);
    chk("st_rdy1", 32'(in_ready), 32'd1);
    step();
    chk("st_ov0",   32'(out_valid), 32'd0);
    chk("st_slot1", 32'(slot),      32'd1);
    cyc(1'b1, 4'h6, 1'b0, 1'b1);
    chk("st_e6", 32'(out_data), 32'(exw(4'hE, 4'h6)));
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Nibble 7 then flush
    cyc(1'b1, 4'h7, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("fl_ov",   32'(out_valid), 32'd1);
    chk("fl_data", 32'(out_data),  32'(exw(4'h7, 4'h0)));
    chk("fl_pad",  32'(out_pad),   32'd1);
    chk("fl_slot", 32'(slot),      32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("fl_off", 32'(out_valid), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("fl_empty", 32'(out_valid), 32'd0);

    // Flush coincident with the completing nibble
    cyc(1'b1, 4'h8, 1'b0, 1'b1);
    cyc(1'b1, 4'h9, 1'b1, 1'b1);
    chk("fc_data", 32'(out_data),  32'(exw(4'h8, 4'h9)));
    chk("fc_pad",  32'(out_pad),   32'd0);
    chk("fc_ov",   32'(out_valid), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("fc_one", 32'(out_valid), 32'd0);

    // Reset mid-word
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    chk("rw_slot1", 32'(slot), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_slot", 32'(slot),      32'd0);
    chk("rw_ov",   32'(out_valid), 32'd0);
    chk("rw_data", 32'(out_data),  32'd0);
    rst_n = 1'b1;
    // Reset while full
    cyc(1'b1, 4'h6, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    chk("rf_pre", 32'(out_data), 32'(exw(4'h6, 4'h7)));
    rst_n = 1'b0;
    #1;
    chk("rf_ov",   32'(out_valid), 32'd0);
    chk("rf_slot", 32'(slot),      32'd0);
    chk("rf_data", 32'(out_data),  32'd0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h2, 1'b0, 1'b1);
    cyc(1'b1, 4'h9, 1'b0, 1'b1);
    chk("rc_data", 32'(out_data), 32'(exw(4'h2, 4'h9)));
    chk("rc_pad",  32'(out_pad),  32'd0);
    cyc(1'b1, 4'h4, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("rc_pdata", 32'(out_data), 32'(exw(4'h4, 4'h0)));
    chk("rc_ppad",  32'(out_pad),  32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
